// File: rtl/fir_chk_pkg.sv
// Shared constants and helpers for the FIR lockstep checker.
// Imported by the checker top and its delay line.
package fir_chk_pkg;

    localparam logic [1:0] ST_WARM  = 2'd0;
    localparam logic [1:0] ST_CHECK = 2'd1;
    localparam logic [1:0] ST_FAIL  = 2'd2;

    localparam int LAG_MAX = 15;

    // Ceiling log2; returns 0 for values of 0 or 1.
    function automatic int calc_clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/sample_delay_line.sv
// Shift register that delays the golden path by DEPTH valid samples.
// DEPTH=0 degenerates to a combinational passthrough.
module sample_delay_line
    import fir_chk_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 0
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    generate
        if (DEPTH == 0) begin : g_passthrough
            logic w_unused_ctrl;
            assign w_unused_ctrl = ^{i_clk, i_reset, i_en};
            assign o_data        = i_data;
        end else begin : g_shift
            logic [WIDTH-1:0] r_taps [DEPTH];

            // Advance the taps only on valid samples so lag is measured in samples, not cycles.
            always_ff @(posedge i_clk) begin
                if (i_reset) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        r_taps[i] <= '0;
                    end
                end else if (i_en) begin
                    r_taps[0] <= i_data;
                    for (int i = 1; i < DEPTH; i++) begin
                        r_taps[i] <= r_taps[i-1];
                    end
                end
            end

            assign o_data = r_taps[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/fir_lockstep_checker.sv
// Lockstep miter between a golden and a candidate FIR output stream:
// lag alignment, warm-up masking, saturating error count and first-failure capture.
module fir_lockstep_checker
    import fir_chk_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int CHANNELS = 1,
    parameter int LAG      = 0,
    parameter int WARMUP   = 16,
    parameter int CNT_W    = 16,
    localparam int CHAN_W  = (CHANNELS > 1) ? calc_clog2(CHANNELS) : 1,
    localparam int BUS_W   = CHANNELS * DATA_W
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_valid,
    input  logic [BUS_W-1:0]  i_data_a,
    input  logic [BUS_W-1:0]  i_data_b,
    input  logic              i_clear,
    output logic              o_armed,
    output logic              o_mismatch,
    output logic              o_sticky,
    output logic [CNT_W-1:0]  o_err_count,
    output logic [CHAN_W-1:0] o_first_chan,
    output logic [DATA_W-1:0] o_first_a,
    output logic [DATA_W-1:0] o_first_b
);

    localparam int WCNT_W = (WARMUP > 0) ? calc_clog2(WARMUP + 1) : 1;

    generate
        if (LAG < 0 || LAG > LAG_MAX || WARMUP < LAG) begin : g_bad_params
            $error("fir_lockstep_checker: LAG must be 0..15 and WARMUP must be >= LAG");
        end
    endgenerate

    logic [BUS_W-1:0]  w_aligned_a;
    logic [CHANNELS-1:0] w_diff;
    logic [CHAN_W-1:0] w_first_chan;
    logic [DATA_W-1:0] w_first_a;
    logic [DATA_W-1:0] w_first_b;
    logic              w_warm_hit;
    logic              w_cmp_mis;
    logic [1:0]        w_state_next;

    logic [1:0]        r_state;
    logic              r_armed;
    logic [WCNT_W-1:0] r_warm_cnt;
    logic              r_mismatch;
    logic              r_sticky;
    logic [CNT_W-1:0]  r_err_count;
    logic [CHAN_W-1:0] r_first_chan;
    logic [DATA_W-1:0] r_first_a;
    logic [DATA_W-1:0] r_first_b;

    sample_delay_line #(
        .WIDTH (BUS_W),
        .DEPTH (LAG)
    ) u_delay (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_en    (i_valid),
        .i_data  (i_data_a),
        .o_data  (w_aligned_a)
    );

    // Per-channel compare; scanning downward leaves the lowest differing channel selected.
    always_comb begin
        w_diff       = '0;
        w_first_chan = '0;
        w_first_a    = '0;
        w_first_b    = '0;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            w_diff[k]    = (w_aligned_a[k*DATA_W +: DATA_W] != i_data_b[k*DATA_W +: DATA_W]);
            w_first_chan = w_diff[k] ? CHAN_W'(k) : w_first_chan;
            w_first_a    = w_diff[k] ? w_aligned_a[k*DATA_W +: DATA_W] : w_first_a;
            w_first_b    = w_diff[k] ? i_data_b[k*DATA_W +: DATA_W] : w_first_b;
        end
    end

    assign w_warm_hit = (int'(r_warm_cnt) + 1 >= WARMUP);
    assign w_cmp_mis  = i_valid && (r_state != ST_WARM) && (|w_diff);

    // Next-state decode; the sample that completes warm-up is not itself compared.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_WARM:  w_state_next = (i_valid && w_warm_hit) ? ST_CHECK : ST_WARM;
            ST_CHECK: w_state_next = (w_cmp_mis && !i_clear) ? ST_FAIL : ST_CHECK;
            ST_FAIL:  w_state_next = i_clear ? ST_CHECK : ST_FAIL;
            default:  w_state_next = ST_WARM;
        endcase
    end

    // State register with armed flag registered alongside it.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_WARM;
            r_armed <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_armed <= (w_state_next != ST_WARM);
        end
    end

    // Warm-up sample counter, frozen once it reaches WARMUP.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_warm_cnt <= '0;
        end else if (i_valid && (int'(r_warm_cnt) < WARMUP)) begin
            r_warm_cnt <= r_warm_cnt + WCNT_W'(1);
        end
    end

    // Mismatch pulse, sticky flag, saturating count and first-failure capture; clear beats a same-cycle mismatch.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            r_mismatch   <= 1'b0;
            r_sticky     <= 1'b0;
            r_err_count  <= '0;
            r_first_chan <= '0;
            r_first_a    <= '0;
            r_first_b    <= '0;
        end else begin
            r_mismatch <= w_cmp_mis;
            if (w_cmp_mis) begin
                r_sticky <= 1'b1;
                if (r_err_count != {CNT_W{1'b1}}) begin
                    r_err_count <= r_err_count + CNT_W'(1);
                end
                if (!r_sticky) begin
                    r_first_chan <= w_first_chan;
                    r_first_a    <= w_first_a;
                    r_first_b    <= w_first_b;
                end
            end
        end
    end

    assign o_armed      = r_armed;
    assign o_mismatch   = r_mismatch;
    assign o_sticky     = r_sticky;
    assign o_err_count  = r_err_count;
    assign o_first_chan = r_first_chan;
    assign o_first_a    = r_first_a;
    assign o_first_b    = r_first_b;

endmodule

// File: doc/fir_lockstep_checker.md
Name: fir_lockstep_checker

Overview:
- Parametrised, multi-channel successor to the hsFIR reference-vs-mutant miter.
- Sits between a golden FIR instance (path A) and a candidate FIR instance (path B). Both are driven from the same i_clk and input stream.
- Aligns the two output streams by a fixed sample lag and masks a warm-up window after reset.
- Reports mismatches per sample, keeps a saturating error count, and captures the first failing sample for debug.
- Synthesisable, so it can be used in formal equivalence runs and in on-FPGA lockstep self-test.

Parameters:
- DATA_W, 8, width of one channel sample.
- CHANNELS, 1, number of parallel channels packed in each data bus.
- LAG, 0, number of valid samples by which path A is delayed before comparison (0..15).
- WARMUP, 16, number of valid samples ignored after reset. Must be >= LAG; elaboration error otherwise.
- CNT_W, 16, width of the error counter.

Ports:
- i_clk  in  1  system clock.
- i_reset  in  1  synchronous, active-high reset.
- i_valid  in  1  both data buses carry a sample this cycle.
- i_data_a  in  CHANNELS*DATA_W  golden output; channel k at bits [k*DATA_W +: DATA_W].
- i_data_b  in  CHANNELS*DATA_W  candidate output; same packing.
- i_clear  in  1  clears counters, sticky flag and capture registers; does not re-enter warm-up.
- o_armed  out  1  comparison active (state CHECK or FAIL).
- o_mismatch  out  1  one-cycle pulse; the previous valid compared sample mismatched.
- o_sticky  out  1  set on first mismatch; held until i_clear or i_reset.
- o_err_count  out  CNT_W  mismatching samples since reset/clear; saturates at all-ones.
- o_first_chan  out  clog2(CHANNELS) (min 1)  lowest mismatching channel index of the first failing sample.
- o_first_a  out  DATA_W  aligned path-A value on that channel.
- o_first_b  out  DATA_W  path-B value on that channel.

Behaviour:
- Reset (i_clk edge with i_reset=1):
  - All outputs go to 0.
  - State goes to WARM.
  - Warm-up counter and delay-line contents go to 0.
  - Reset mid-operation discards all history.
- Delay line: LAG-deep shift register of path-A words. It advances only when i_valid=1. When LAG=0, the aligned A word is i_data_a directly.
- Warm-up counter: counts valid samples from 0 up to WARMUP. It freezes at WARMUP.
- States:
  - WARM -> CHECK on the valid sample that brings the counter to WARMUP. That sample itself is not compared.
  - CHECK -> FAIL on the first compared mismatch.
  - FAIL -> CHECK on i_clear.
  - CHECK + i_clear stays in CHECK.
  - WARM ignores i_clear.
- Compare:
  - Occurs only when i_valid=1 and the state is CHECK or FAIL.
  - Per-channel inequality between the aligned A word and the B word.
  - The sample mismatches if any channel differs.
- Latency: o_mismatch, o_err_count and the capture registers update on the clock edge that samples the mismatching input, so they are visible the next cycle. o_mismatch is low in any cycle without a compared mismatch.
- Capture:
  - Loads only when o_sticky is 0 at the time of the mismatch (first failure only).
  - The channel is chosen as the lowest index among the mismatching channels.
  - Later mismatches do not overwrite the capture.
- Counter:
  - +1 per mismatching sample, not per channel.
  - Holds at 2^CNT_W-1 while o_mismatch still pulses and o_sticky stays 1.
- i_clear together with a mismatching sample in the same cycle:
  - Clear wins: count=0, sticky=0, captures=0, o_mismatch=0, state=CHECK.
  - That sample is not counted.
- i_reset together with i_clear: reset wins.
- i_valid=0: nothing changes except clearing o_mismatch. i_clear still acts.

Decomposition:
- Package fir_chk_pkg:
  - state encoding localparams ST_WARM=2'd0, ST_CHECK=2'd1, ST_FAIL=2'd2;
  - clog2 helper function;
  - LAG maximum (15).
- One sub-module: sample_delay_line.
  - Parameters WIDTH and DEPTH; ports i_clk, i_reset, i_en, i_data, o_data.
  - Combinational passthrough when DEPTH=0.
- Comparator, priority encoder, FSM and counter stay in the top module.

Test Plan:
- Equal streams: CHANNELS=2, LAG=0, WARMUP=4. Ramp 0..63 on both buses, i_valid=1 throughout -> o_armed rises after the 4th sample; o_mismatch never 1; o_err_count=0.
- Single fault:
  - Inject B=0xA5 vs A=0x5A on channel 1 at compared sample 10 -> one o_mismatch pulse the cycle after.
  - o_sticky=1, o_err_count=1, o_first_chan=1, o_first_a=0x5A, o_first_b=0xA5.
- Lag alignment: LAG=3, WARMUP=5. Drive B as A delayed by 3 samples -> zero mismatches. The same run with LAG=2 -> o_err_count counts every compared sample.
- Multi-channel priority: first fault on channels 3 and 1 simultaneously -> o_first_chan=1. A later fault on channel 0 leaves the capture unchanged; o_err_count=2.
- Saturation and clear:
  - CNT_W=3, continuous mismatch -> count holds at 7.
  - i_clear asserted on a mismatching sample -> count=0, sticky=0, state CHECK, next cycle o_mismatch=0.
- Reset mid-run: assert i_reset in FAIL with count=5 -> all outputs 0, o_armed=0. The next WARMUP valid samples are ignored even if they differ.
